// File: rtl/serial_rca_pkg.sv
// Shared types and defaults for the bit-serial ripple-carry adder.
package serial_rca_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_rca_adder_full_adder.sv
// One-bit combinational full-adder slice; the carry register lives in the parent.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_rca_adder.sv
// Bit-serial unsigned adder: one bit per clock, LSB first, through a single
// full-adder slice with a registered carry; valid/ready on both sides.
module serial_rca_adder
    import serial_rca_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c;

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    assign in_ready = (state == IDLE);

    // Sum bits enter S at the MSB so bit 0 lands in S[0] after WIDTH shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            S         <= '0;
            Cout      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr  <= A;
                        b_sr  <= B;
                        carry <= 1'b0;
                        cnt   <= '0;
                        S     <= '0;
                        Cout  <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    S     <= {fa_s, S[WIDTH-1:1]};
                    carry <= fa_c;
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        Cout      <= fa_c;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_rca_adder.sv
// Randomised self-checking bench for serial_rca_adder at WIDTH=4 and WIDTH=8,
// against a plain-arithmetic model of unsigned addition.
module tb_serial_rca_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sel8 = 1'b0;
    logic       iv = 1'b0;
    logic       ordy = 1'b0;
    logic [7:0] a_drv = '0;
    logic [7:0] b_drv = '0;

    logic       ir4, ov4, c4, busy4;
    logic [3:0] s4;
    logic       ir8, ov8, c8, busy8;
    logic [7:0] s8;

    logic       ir, ov, co, bz;
    logic [7:0] sm;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_rca_adder #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv & ~sel8),
        .in_ready  (ir4),
        .A         (a_drv[3:0]),
        .B         (b_drv[3:0]),
        .out_valid (ov4),
        .out_ready (ordy & ~sel8),
        .S         (s4),
        .Cout      (c4),
        .busy      (busy4)
    );

    serial_rca_adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv & sel8),
        .in_ready  (ir8),
        .A         (a_drv),
        .B         (b_drv),
        .out_valid (ov8),
        .out_ready (ordy & sel8),
        .S         (s8),
        .Cout      (c8),
        .busy      (busy8)
    );

    assign ir = sel8 ? ir8 : ir4;
    assign ov = sel8 ? ov8 : ov4;
    assign co = sel8 ? c8 : c4;
    assign bz = sel8 ? busy8 : busy4;
    assign sm = sel8 ? s8 : {4'b0, s4};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned width_now();
        return sel8 ? 8 : 4;
    endfunction

    // Reference: plain unsigned sum, split into low WIDTH bits and carry.
    function automatic logic [8:0] model(input int unsigned a, input int unsigned b);
        int unsigned w, tot;
        w   = width_now();
        tot = a + b;
        return {1'(tot >> w), 8'(tot % (32'd1 << w))};
    endfunction

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!ir && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("wait_in_ready", 32'(ir), 32'd1);
    endtask

    // One transaction with `hold` cycles of back-pressure in DONE.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold);
        logic [8:0] exp;
        int unsigned lat;
        int unsigned w;
        w   = width_now();
        exp = model(int'(a), int'(b));
        wait_idle();
        a_drv = a;
        b_drv = b;
        iv    = 1'b1;
        ordy  = 1'b0;
        @(posedge clk);
        #1;
        a_drv = 8'($urandom);
        b_drv = 8'($urandom);
        lat   = 0;
        @(negedge clk);
        check("run_busy", 32'(bz), 32'd1);
        check("run_in_ready", 32'(ir), 32'd0);
        while (!ov && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("latency", lat, w);
        check("sum", 32'(sm), 32'(exp[7:0]));
        check("cout", 32'(co), 32'(exp[8]));
        check("done_busy", 32'(bz), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_out_valid", 32'(ov), 32'd1);
            check("hold_in_ready", 32'(ir), 32'd0);
            check("hold_sum", 32'(sm), 32'(exp[7:0]));
        end
        ordy = 1'b1;
        @(posedge clk);
        #1;
        check("release_out_valid", 32'(ov), 32'd0);
        check("release_in_ready", 32'(ir), 32'd1);
        check("release_keep_sum", 32'(sm), 32'(exp[7:0]));
        iv   = 1'b0;
        ordy = 1'b0;
    endtask

    // Back-to-back: in_valid and out_ready held high across three pairs.
    task automatic run_b2b(input logic [7:0] pa[3], input logic [7:0] pb[3]);
        logic [8:0] exp[3];
        int idx_in = 0;
        int idx_out = 0;
        int last = 0;
        logic acc;
        for (int i = 0; i < 3; i++) exp[i] = model(int'(pa[i]), int'(pb[i]));
        wait_idle();
        a_drv = pa[0];
        b_drv = pb[0];
        iv    = 1'b1;
        ordy  = 1'b1;
        for (int c = 0; c < 80 && idx_out < 3; c++) begin
            if (c > 0) @(negedge clk);
            if (ov) begin
                check("b2b_sum", 32'(sm), 32'(exp[idx_out][7:0]));
                check("b2b_cout", 32'(co), 32'(exp[idx_out][8]));
                if (idx_out > 0) check("b2b_spacing", 32'(c - last), width_now() + 2);
                last = c;
                idx_out++;
            end
            acc = iv & ir;
            @(posedge clk);
            #1;
            if (acc) begin
                idx_in++;
                if (idx_in < 3) begin
                    a_drv = pa[idx_in];
                    b_drv = pb[idx_in];
                end else begin
                    iv = 1'b0;
                end
            end
        end
        check("b2b_count", 32'(idx_out), 32'd3);
        iv   = 1'b0;
        ordy = 1'b0;
    endtask

    initial begin
        logic [7:0] pa[3];
        logic [7:0] pb[3];
        #12;
        check("rst_in_ready4", 32'(ir4), 32'd1);
        check("rst_out_valid4", 32'(ov4), 32'd0);
        check("rst_busy4", 32'(busy4), 32'd0);
        check("rst_sum4", 32'(s4), 32'd0);
        check("rst_cout4", 32'(c4), 32'd0);
        check("rst_out_valid8", 32'(ov8), 32'd0);
        check("rst_in_ready8", 32'(ir8), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'h0, 8'h0, 0);
        run_op(8'h5, 8'h3, 0);
        run_op(8'h9, 8'h6, 0);
        run_op(8'hF, 8'h1, 1);
        run_op(8'hF, 8'hF, 5);

        // Reset two cycles into RUN must abort with no valid result.
        wait_idle();
        a_drv = 8'h7;
        b_drv = 8'h1;
        iv    = 1'b1;
        @(posedge clk);
        #1;
        iv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(ov4), 32'd0);
        check("mid_rst_in_ready", 32'(ir4), 32'd1);
        check("mid_rst_busy", 32'(busy4), 32'd0);
        check("mid_rst_sum", 32'(s4), 32'd0);
        check("mid_rst_cout", 32'(c4), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h7, 8'h1, 0);

        pa = '{8'h3, 8'hC, 8'hF};
        pb = '{8'h4, 8'h5, 8'h2};
        run_b2b(pa, pb);

        for (int i = 0; i < 15; i++)
            run_op(8'($urandom_range(15)), 8'($urandom_range(15)), int'($urandom_range(3)));

        sel8 = 1'b1;
        run_op(8'd200, 8'd100, 2);
        run_op(8'hFF, 8'h01, 0);
        for (int i = 0; i < 10; i++)
            run_op(8'($urandom), 8'($urandom), int'($urandom_range(2)));
        pa = '{8'($urandom), 8'($urandom), 8'hFF};
        pb = '{8'($urandom), 8'($urandom), 8'hFF};
        run_b2b(pa, pb);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_rca_adder.md
Name: serial_rca_adder

Overview:
- Bit-serial unsigned adder. It computes S = A + B with carry-out Cout, the additive counterpart to the team's four-bit ripple-carry subtractor.
- It processes one bit per clock, LSB first, through a single registered-carry full-adder slice.
- Operands are accepted with a valid/ready handshake, and the result is presented with a valid/ready handshake.
- It sits between an operand source and a result sink. It replaces a WIDTH-wide combinational carry chain when area matters more than latency.

Parameters:
- WIDTH, 4, operand and sum width in bits (legal range 2..32)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands A/B are valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- A  input  WIDTH  addend, sampled on in_valid & in_ready
- B  input  WIDTH  addend, sampled on in_valid & in_ready
- out_valid  output  1  S/Cout hold a completed result
- out_ready  input  1  sink accepts the result
- S  output  WIDTH  sum bits, registered
- Cout  output  1  carry out of bit WIDTH-1 (unsigned overflow), registered
- busy  output  1  high in RUN

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, in_ready=1 (combinational from state), out_valid=0, busy=0, S=0, Cout=0, internal carry=0, bit counter=0, operand shift registers=0.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid=1, load A and B into shift registers, clear carry, clear counter, clear S, go to RUN. Otherwise stay in IDLE.
  - RUN: in_ready=0, busy=1. Each cycle:
    - the full-adder slice sums the shift-register LSBs plus carry;
    - the sum bit shifts into S from the MSB end (after WIDTH shifts, S[0] holds bit 0);
    - the carry register takes the slice carry-out;
    - both operand registers shift right by 1;
    - the counter increments.
  - RUN exit: on the cycle the counter equals WIDTH-1, the final bit is processed, Cout is loaded with the final carry, and the FSM goes to DONE.
  - DONE: out_valid=1; S and Cout are stable. On out_ready=1, go to IDLE with out_valid=0. S and Cout keep their value until the next accept.
- Latency: operands accepted at edge N; out_valid rises after edge N+WIDTH; the RUN state lasts exactly WIDTH cycles.
- Throughput: one result per WIDTH+2 cycles when out_ready is held high.
- Back-pressure: DONE holds indefinitely while out_ready=0. in_valid is ignored outside IDLE; the source must hold A/B until the handshake.
- Simultaneous out_ready (DONE) and in_valid: no accept that cycle, because in_ready is 0. The operands are accepted the following cycle in IDLE.
- Arithmetic:
  - Pure unsigned addition modulo 2^WIDTH.
  - Cout=1 iff A+B >= 2^WIDTH.
  - No signed overflow flag.
- Counter width is $clog2(WIDTH); wrap is not reachable because RUN exits at WIDTH-1.
- Reset mid-operation (RUN or DONE): all state returns to the reset values immediately. No partial result is ever flagged valid.
- A/B changing during RUN has no effect, because only the shift registers are used.

Decomposition:
- Package serial_rca_pkg: typedef enum logic [1:0] {IDLE, RUN, DONE} state_t; localparam DEFAULT_WIDTH = 4.
- Sub-module full_adder (a, b, cin -> s, cout), purely combinational. It is instantiated once; the carry register lives in the parent.

Test Plan:
- Reset, then A=0000, B=0000 with in_valid pulse -> after 4 RUN cycles out_valid=1, S=0000, Cout=0.
- A=0101, B=0011 -> S=1000, Cout=0; out_valid rises exactly 4 cycles after the accept edge.
- A=1001, B=0110 -> S=1111, Cout=0. Then A=1111, B=0001 -> S=0000, Cout=1.
- A=1111, B=1111 with out_ready held 0 for 5 cycles:
  - S=1110, Cout=1, and out_valid stays high throughout;
  - in_ready=0 and a concurrent in_valid is not accepted;
  - out_ready=1 returns the FSM to IDLE.
- rst_n pulsed low 2 cycles into RUN of A=0111, B=0001 -> S=0000, Cout=0, out_valid=0, in_ready=1 immediately; a new operation afterwards completes correctly.
- Back-to-back: in_valid and out_ready held high, 3 operand pairs -> 3 correct results, each WIDTH+2 cycles apart. WIDTH=8 rerun: 200+100 -> S=0x2C, Cout=1.
